// File: rtl/pio_avail_fifo.sv
// pio_avail_fifo: drains CPU-written PIO words into a small FIFO and acks each
// one immediately, then presents the buffered words on a show-ahead
// valid/ready stream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   update_avail/rddata PIO word presented by the CPU register
//   read_rst            ack to the PIO (combinational, high in the push cycle)
//   flush               synchronous clear of contents and status
//   out_valid/out_data  stream word (show-ahead), out_ready accepts it
//   fill_level          current occupancy 0..DEPTH
//   backpressure        sticky: a PIO word was waiting while the FIFO was full
//
// Optional build macro PIO_AVAIL_FIFO_STATS_EN adds:
//   peak_level          highest occupancy since reset/flush
//   drop_stall_cycles   saturating count of cycles a PIO word waited on a full FIFO
module pio_avail_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        update_avail,
    input  logic [DATA_WIDTH-1:0]       rddata,
    output logic                        read_rst,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic                        backpressure
`ifdef PIO_AVAIL_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]      peak_level,
    output logic [15:0]                 drop_stall_cycles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full       = (count == CW'(DEPTH));
    assign out_valid  = (count != CW'(0));
    assign out_data   = mem[rd_ptr];
    assign fill_level = count;

    // Gating with rst_n keeps the ack low while reset is held, so the PIO
    // keeps its word until the first post-reset cycle.
    assign push     = rst_n & update_avail & ~full & ~flush;
    assign pop      = out_valid & out_ready & ~flush;
    assign read_rst = push;

    // Next occupancy; shared by the count register and peak tracking.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Storage, pointers, occupancy and sticky overflow status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            backpressure <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            backpressure <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rddata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            if (update_avail && full) begin
                backpressure <= 1'b1;
            end
        end
    end

`ifdef PIO_AVAIL_FIFO_STATS_EN
    // Peak occupancy and full-stall cycle statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_level        <= '0;
            drop_stall_cycles <= '0;
        end else if (flush) begin
            peak_level        <= '0;
            drop_stall_cycles <= '0;
        end else begin
            if (count_nxt > peak_level) begin
                peak_level <= count_nxt;
            end
            if (update_avail && full && (drop_stall_cycles != 16'hFFFF)) begin
                drop_stall_cycles <= drop_stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
